// File: rtl/lcd_char_render.sv
// Draws one glyph on the ST7735: sends CASET/RASET/RAMWR, then streams RGB565 pixel bytes
// to the SPI byte writer. Glyph rows come from an external font ROM.
module lcd_char_render #(
   parameter int unsigned X_OFS     = 0,
   parameter int unsigned Y_OFS     = 0,
   parameter int unsigned GUARD_CYC = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_done,
   input  logic        show_char_flag,
   input  logic [7:0]  ascii_num,
   input  logic [8:0]  start_x,
   input  logic [8:0]  start_y,
   input  logic        en_size,
   input  logic [15:0] background_color,
   input  logic [15:0] front_color,
   output logic [11:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        spi_req,
   output logic [8:0]  spi_data,
   input  logic        spi_ack,
   output logic        busy,
   output logic        show_char_done
);

   localparam int unsigned GW = 8;
   localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYC);
   localparam logic [3:0]    LAST_CMD  = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_FETCH,
      S_PIX_HI,
      S_PIX_LO
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] guard_q, guard_d;
   logic [6:0]    glyph_q, glyph_d;
   logic [8:0]    x_q, x_d;
   logic [8:0]    y_q, y_d;
   logic          size_q, size_d;
   logic [15:0]   bg_q, bg_d;
   logic [15:0]   fg_q, fg_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    row_q, row_d;
   logic [2:0]    col_q, col_d;
   logic          fetch_q, fetch_d;
   logic [7:0]    row_byte_q, row_byte_d;
   logic          req_q, req_d;
   logic [8:0]    data_q, data_d;
   logic [11:0]   rom_addr_q, rom_addr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [15:0] x0, x1, y0, y1;
   logic [2:0]  last_col;
   logic [3:0]  last_row;
   logic [8:0]  setup_byte;
   logic [15:0] colour;

   // Window geometry and the current pixel colour, all from the latched copies
   always_comb begin
      x0       = 16'(x_q) + 16'(X_OFS);
      y0       = 16'(y_q) + 16'(Y_OFS);
      x1       = x0 + (size_q ? 16'd7 : 16'd5);
      y1       = y0 + (size_q ? 16'd15 : 16'd11);
      last_col = size_q ? 3'd7 : 3'd5;
      last_row = size_q ? 4'd15 : 4'd11;
      colour   = row_byte_q[3'd7 - col_q] ? fg_q : bg_q;
      case (idx_q)
         4'd0:    setup_byte = {1'b0, 8'h2A};
         4'd1:    setup_byte = {1'b1, x0[15:8]};
         4'd2:    setup_byte = {1'b1, x0[7:0]};
         4'd3:    setup_byte = {1'b1, x1[15:8]};
         4'd4:    setup_byte = {1'b1, x1[7:0]};
         4'd5:    setup_byte = {1'b0, 8'h2B};
         4'd6:    setup_byte = {1'b1, y0[15:8]};
         4'd7:    setup_byte = {1'b1, y0[7:0]};
         4'd8:    setup_byte = {1'b1, y1[15:8]};
         4'd9:    setup_byte = {1'b1, y1[7:0]};
         4'd10:   setup_byte = {1'b0, 8'h2C};
         default: setup_byte = 9'd0;
      endcase
   end

   // Next-state: each byte state presents its byte when req is low, advances on ack
   always_comb begin
      state_d    = state_q;
      guard_d    = guard_q;
      glyph_d    = glyph_q;
      x_d        = x_q;
      y_d        = y_q;
      size_d     = size_q;
      bg_d       = bg_q;
      fg_d       = fg_q;
      idx_d      = idx_q;
      row_d      = row_q;
      col_d      = col_q;
      fetch_d    = fetch_q;
      row_byte_d = row_byte_q;
      req_d      = req_q;
      data_d     = data_q;
      rom_addr_d = rom_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (init_done && show_char_flag && guard_q == GUARD_MAX) begin
               glyph_d = (ascii_num > 8'd94) ? 7'd0 : ascii_num[6:0];
               x_d     = start_x;
               y_d     = start_y;
               size_d  = en_size;
               bg_d    = background_color;
               fg_d    = front_color;
               idx_d   = 4'd0;
               row_d   = 4'd0;
               col_d   = 3'd0;
               busy_d  = 1'b1;
               guard_d = '0;
               state_d = S_CMD;
            end else if (guard_q < GUARD_MAX) begin
               guard_d = guard_q + GW'(1);
            end
         end

         S_CMD: begin
            if (!req_q) begin
               req_d  = 1'b1;
               data_d = setup_byte;
            end else if (spi_ack) begin
               req_d = 1'b0;
               if (idx_q == LAST_CMD) begin
                  rom_addr_d = {size_q, glyph_q, 4'd0};
                  fetch_d    = 1'b0;
                  state_d    = S_FETCH;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end

         // One cycle for the ROM to register the address, then capture the row byte
         S_FETCH: begin
            if (!fetch_q) begin
               fetch_d = 1'b1;
            end else begin
               row_byte_d = rom_data;
               state_d    = S_PIX_HI;
            end
         end

         S_PIX_HI: begin
            if (!req_q) begin
               req_d  = 1'b1;
               data_d = {1'b1, colour[15:8]};
            end else if (spi_ack) begin
               req_d   = 1'b0;
               state_d = S_PIX_LO;
            end
         end

         S_PIX_LO: begin
            if (!req_q) begin
               req_d  = 1'b1;
               data_d = {1'b1, colour[7:0]};
               if (col_q == last_col && row_q != last_row) begin
                  rom_addr_d = {size_q, glyph_q, row_q + 4'd1};
               end
            end else if (spi_ack) begin
               req_d = 1'b0;
               if (col_q == last_col) begin
                  col_d = 3'd0;
                  if (row_q == last_row) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     row_d   = row_q + 4'd1;
                     fetch_d = 1'b0;
                     state_d = S_FETCH;
                  end
               end else begin
                  col_d   = col_q + 3'd1;
                  state_d = S_PIX_HI;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         guard_q    <= GUARD_MAX;
         glyph_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         size_q     <= 1'b0;
         bg_q       <= '0;
         fg_q       <= '0;
         idx_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         fetch_q    <= 1'b0;
         row_byte_q <= '0;
         req_q      <= 1'b0;
         data_q     <= '0;
         rom_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         guard_q    <= guard_d;
         glyph_q    <= glyph_d;
         x_q        <= x_d;
         y_q        <= y_d;
         size_q     <= size_d;
         bg_q       <= bg_d;
         fg_q       <= fg_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         col_q      <= col_d;
         fetch_q    <= fetch_d;
         row_byte_q <= row_byte_d;
         req_q      <= req_d;
         data_q     <= data_d;
         rom_addr_q <= rom_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr       = rom_addr_q;
   assign spi_req        = req_q;
   assign spi_data       = data_q;
   assign busy           = busy_q;
   assign show_char_done = done_q;

endmodule

// File: tb/tb_lcd_char_render.sv
// Bench for lcd_char_render: a byte-list model of each character, checked against the SPI
// stream every cycle, with two instances so panel offsets can be exercised.
`timescale 1ns/1ps
module tb_lcd_char_render;

   typedef logic [9:0] ent_t;   // {tight, dc, byte}; tight = must follow previous byte after 1 idle cycle
   typedef ent_t q_t[$];

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic        init_done, flag, size, sel, spi_ack, force_a5;
   logic [7:0]  ascii;
   logic [8:0]  sx, sy;
   logic [15:0] bg, fg;
   logic [11:0] rom_addr0, rom_addr1;
   logic [7:0]  rom_data0, rom_data1;
   logic        req0, req1, busy0, busy1, done0, done1;
   logic [8:0]  data0, data1;

   wire         req      = sel ? req1 : req0;
   wire  [8:0]  data     = sel ? data1 : data0;
   wire         busy     = sel ? busy1 : busy0;
   wire         done     = sel ? done1 : done0;
   wire  [11:0] rom_addr = sel ? rom_addr1 : rom_addr0;

   int n_vec = 0, n_err = 0;

   function automatic logic [7:0] font(input logic [11:0] a);
      logic [11:0] m;
      if (force_a5 && a[3:0] == 4'd0) return 8'hA5;
      m = a * 12'd37;
      return m[11:4] ^ {a[3:0], a[7:4]};
   endfunction

   always @(posedge sys_clk) rom_data0 <= font(rom_addr0);
   always @(posedge sys_clk) rom_data1 <= font(rom_addr1);

   lcd_char_render #(.X_OFS(0), .Y_OFS(0), .GUARD_CYC(2)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
      .show_char_flag(flag & ~sel), .ascii_num(ascii), .start_x(sx), .start_y(sy),
      .en_size(size), .background_color(bg), .front_color(fg),
      .rom_addr(rom_addr0), .rom_data(rom_data0), .spi_req(req0), .spi_data(data0),
      .spi_ack(spi_ack & ~sel), .busy(busy0), .show_char_done(done0));

   lcd_char_render #(.X_OFS(2), .Y_OFS(1), .GUARD_CYC(2)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
      .show_char_flag(flag & sel), .ascii_num(ascii), .start_x(sx), .start_y(sy),
      .en_size(size), .background_color(bg), .front_color(fg),
      .rom_addr(rom_addr1), .rom_data(rom_data1), .spi_req(req1), .spi_data(data1),
      .spi_ack(spi_ack & sel), .busy(busy1), .show_char_done(done1));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected byte stream of one character, straight from the drawing rules
   task automatic build(input logic [7:0] a, input logic [8:0] x, input logic [8:0] y,
                        input logic sz, input logic [15:0] b, input logic [15:0] f,
                        input int xo, input int yo, output q_t q);
      int w, h;
      logic [15:0] x0, x1, y0, y1, c;
      logic [6:0] g;
      logic [7:0] r;
      q = {};
      w = sz ? 8 : 6;
      h = sz ? 16 : 12;
      x0 = 16'(x) + 16'(xo);
      y0 = 16'(y) + 16'(yo);
      x1 = x0 + 16'(w - 1);
      y1 = y0 + 16'(h - 1);
      g = (a > 8'd94) ? 7'd0 : a[6:0];
      q.push_back({2'b00, 8'h2A});
      q.push_back({2'b11, x0[15:8]}); q.push_back({2'b11, x0[7:0]});
      q.push_back({2'b11, x1[15:8]}); q.push_back({2'b11, x1[7:0]});
      q.push_back({2'b10, 8'h2B});
      q.push_back({2'b11, y0[15:8]}); q.push_back({2'b11, y0[7:0]});
      q.push_back({2'b11, y1[15:8]}); q.push_back({2'b11, y1[7:0]});
      q.push_back({2'b10, 8'h2C});
      for (int ri = 0; ri < h; ri++) begin
         r = font({sz, g, 4'(ri)});
         for (int ci = 0; ci < w; ci++) begin
            c = r[7 - ci] ? f : b;
            q.push_back({(ci != 0), 1'b1, c[15:8]});
            q.push_back({2'b11, c[7:0]});
         end
      end
   endtask

   // Model and compare state
   q_t   exp_q;
   bit   m_busy = 0, m_done_exp = 0, m_size = 0, prev_req = 0, prev_busy = 0, t_done_valid = 0;
   int   m_guard = 2, max_dly = 0, ack_wait = 0, low_run = 0, bytes_acked = 0, done_cnt = 0;
   int   cyc = 0, t_done = 0;
   logic [8:0] prev_data = '0;

   always @(negedge sys_clk) begin
      bit was_ack, ending;
      cyc++;
      was_ack = spi_ack;
      spi_ack = 1'b0;
      ending  = 0;
      if (!sys_rst_n) begin
         check("rst_req", req, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         exp_q.delete();
         m_busy = 0; m_done_exp = 0; m_guard = 2; prev_req = 0; prev_busy = 0;
         low_run = 0; ack_wait = 0; bytes_acked = 0; t_done_valid = 0;
      end else begin
         check("busy", busy, m_busy);
         check("done", done, m_done_exp);
         if (done) begin done_cnt++; t_done = cyc; t_done_valid = 1; end
         if (busy && !prev_busy && t_done_valid) check("guard_gap", (cyc - t_done) >= 3, 1);
         m_done_exp = 0;
         if (was_ack) begin
            check("req_drop", req, 0);
         end else if (req) begin
            if (!prev_req) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL extra_byte: got %h expected no request", data);
               end else if (exp_q[0][9]) begin
                  check("idle_gap", low_run, 1);
               end
               ack_wait = $urandom_range(0, max_dly);
            end else begin
               check("stable", data, prev_data);
            end
            if (exp_q.size() > 0) begin
               if (ack_wait == 0) begin
                  check("byte", data, exp_q[0][8:0]);
                  if (bytes_acked >= 11) check("rom_size", rom_addr[11], m_size);
                  void'(exp_q.pop_front());
                  bytes_acked++;
                  spi_ack = 1'b1;
                  if (exp_q.size() == 0) begin
                     m_busy = 0; m_done_exp = 1; m_guard = 0; ending = 1;
                  end
               end else begin
                  ack_wait--;
               end
            end
         end
         if (!m_busy && !ending) begin
            if (init_done && flag && m_guard >= 2) begin
               build(ascii, sx, sy, size, bg, fg, sel ? 2 : 0, sel ? 1 : 0, exp_q);
               m_size = size; m_busy = 1; m_guard = 0; bytes_acked = 0;
            end else if (m_guard < 2) begin
               m_guard++;
            end
         end
         low_run   = req ? 0 : low_run + 1;
         prev_req  = req;
         prev_busy = busy;
      end
      prev_data = data;
   end

   task automatic issue(input logic [7:0] a, input logic [8:0] x, input logic [8:0] y,
                        input logic sz, input logic [15:0] b, input logic [15:0] f);
      @(posedge sys_clk); #1;
      ascii = a; sx = x; sy = y; size = sz; bg = b; fg = f; flag = 1'b1;
      @(posedge sys_clk); #1;
      flag = 1'b0;
      ascii = 8'($urandom); sx = 9'($urandom); sy = 9'($urandom);
      size = ~sz; bg = 16'($urandom); fg = 16'($urandom);
   endtask

   task automatic wait_done(input int target, input string nm);
      int n = 0;
      while (done_cnt < target && n < 8000) begin @(posedge sys_clk); n++; end
      if (done_cnt < target) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: done_cnt=%0d expected %0d", nm, done_cnt, target);
      end
   endtask

   logic [8:0] lit1 [11];
   logic [7:0] lit2 [8];
   logic [7:0] lit3 [16];

   initial begin
      q_t tq;
      int d0, n;
      init_done = 0; flag = 0; ascii = 0; sx = 0; sy = 0; size = 0; bg = 0; fg = 0;
      sel = 0; spi_ack = 0; force_a5 = 0;

      // Hand-computed pins on the model
      lit1 = '{9'h02A, 9'h100, 9'h130, 9'h100, 9'h137, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h10F, 9'h02C};
      build(8'd43, 9'd48, 9'd0, 1'b1, 16'h0000, 16'hFFFF, 0, 0, tq);
      check("pin1_len", tq.size(), 267);
      for (int i = 0; i < 11; i++) check("pin1_setup", tq[i][8:0], lit1[i]);
      lit2 = '{8'h00, 8'h03, 8'h00, 8'h08, 8'h00, 8'h21, 8'h00, 8'h2C};
      build(8'd65, 9'd1, 9'd32, 1'b0, 16'h1234, 16'h5678, 2, 1, tq);
      check("pin2_len", tq.size(), 155);
      for (int i = 0; i < 4; i++) check("pin2_caset", tq[1 + i][7:0], lit2[i]);
      for (int i = 0; i < 4; i++) check("pin2_raset", tq[6 + i][7:0], lit2[4 + i]);
      lit3 = '{8'hF8, 8'h00, 8'h00, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F,
               8'h00, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'hF8, 8'h00};
      force_a5 = 1;
      build(8'd33, 9'd10, 9'd20, 1'b1, 16'h001F, 16'hF800, 0, 0, tq);
      force_a5 = 0;
      for (int i = 0; i < 16; i++) check("pin3_row0", tq[11 + i][7:0], lit3[i]);

      // Reset values
      repeat (3) @(posedge sys_clk); #1;
      check("reset_req", req0, 0);
      check("reset_data", data0, 0);
      check("reset_rom", rom_addr0, 0);
      check("reset_busy", busy0, 0);
      check("reset_done", done0, 0);
      @(posedge sys_clk); #2 sys_rst_n = 1;
      repeat (3) @(posedge sys_clk);

      // Flag ignored while init_done is low
      issue(8'd43, 9'd48, 9'd0, 1'b1, 16'h0000, 16'hFFFF);
      repeat (4) @(posedge sys_clk); #1;
      check("init_low_busy", busy0, 0);
      init_done = 1;

      // 1: 'K' 8x16 at (48,0), single-cycle acks
      max_dly = 0; d0 = done_cnt;
      issue(8'd43, 9'd48, 9'd0, 1'b1, 16'h0000, 16'hFFFF);
      wait_done(d0 + 1, "t1");
      repeat (20) @(posedge sys_clk);
      check("t1_done_count", done_cnt - d0, 1);

      // 2: 6x12 at (1,32) on the offset panel
      sel = 1; d0 = done_cnt;
      issue(8'd65, 9'd1, 9'd32, 1'b0, 16'h1234, 16'h5678);
      wait_done(d0 + 1, "t2");
      repeat (5) @(posedge sys_clk);
      sel = 0;
      repeat (3) @(posedge sys_clk);

      // 3: row 0 reads A5
      force_a5 = 1; d0 = done_cnt;
      issue(8'd33, 9'd10, 9'd20, 1'b1, 16'h001F, 16'hF800);
      wait_done(d0 + 1, "t3");
      force_a5 = 0;
      repeat (5) @(posedge sys_clk);

      // 4: flag every 4 cycles with inputs changing each cycle
      max_dly = 1; d0 = done_cnt;
      for (int k = 0; k < 2400; k++) begin
         @(posedge sys_clk); #1;
         ascii = 8'($urandom_range(0, 94)); sx = 9'($urandom); sy = 9'($urandom);
         size = 1'($urandom); bg = 16'($urandom); fg = 16'($urandom);
         flag = (k % 4 == 0);
      end
      @(posedge sys_clk); #1 flag = 0;
      n = 0;
      while (m_busy && n < 8000) begin @(posedge sys_clk); n++; end
      check("t4_drained", m_busy, 0);
      check("t4_multi", (done_cnt - d0) >= 2, 1);
      repeat (5) @(posedge sys_clk);

      // 5: random ack delays, out-of-range glyph, init_done dropping mid-character
      max_dly = 7; d0 = done_cnt;
      issue(8'd200, 9'd100, 9'd50, 1'b1, 16'hA5A5, 16'h5A5A);
      repeat (100) @(posedge sys_clk);
      init_done = 0;
      wait_done(d0 + 1, "t5a");
      init_done = 1;
      issue(8'd94, 9'd511, 9'd300, 1'b0, 16'h0F0F, 16'hF0F0);
      wait_done(d0 + 2, "t5b");
      repeat (5) @(posedge sys_clk);

      // 6: reset after 40 pixel bytes, then a clean character
      max_dly = 2; d0 = done_cnt;
      issue(8'd43, 9'd20, 9'd40, 1'b1, 16'h0000, 16'hFFFF);
      n = 0;
      while (bytes_acked < 51 && n < 8000) begin @(posedge sys_clk); n++; end
      check("t6_reached_40px", bytes_acked >= 51, 1);
      #2 sys_rst_n = 0;
      #1;
      check("t6_req", req0, 0);
      check("t6_busy", busy0, 0);
      repeat (2) @(posedge sys_clk);
      #2 sys_rst_n = 1;
      repeat (5) @(posedge sys_clk);
      check("t6_no_done", done_cnt - d0, 0);
      issue(8'd43, 9'd20, 9'd40, 1'b1, 16'h0000, 16'hFFFF);
      wait_done(d0 + 1, "t6");
      repeat (10) @(posedge sys_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
